hashtable_access_ctrl: RTL

//  Single-port arbiter/sequencer in front of the subset hash-table RAM (64K x 12b segment table).

---
 rtl/hashtable_pkg.sv | 29 ++
 rtl/ht_result_fifo.sv | 56 +++++
 rtl/hashtable_access_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hashtable_pkg.sv
// Shared widths, entry field positions and the result record for the hash-table access path.
package hashtable_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 12;
  localparam int IDX_W   = 11;
  localparam int TAG_W   = 8;
  localparam int IDX_LSB = 0;
  localparam int IDX_MSB = 10;
  localparam int BIG_BIT = 11;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             big;
    logic [TAG_W-1:0] tag;
  } ht_result_t;

  localparam int RES_W = $bits(ht_result_t);

  function automatic ht_result_t make_result(input logic [DATA_W-1:0] entry,
                                             input logic [TAG_W-1:0]  tag);
    ht_result_t r;
    r.idx = entry[IDX_MSB:IDX_LSB];
    r.big = entry[BIG_BIT];
    r.tag = tag;
    return r;
  endfunction

endpackage

// File: rtl/ht_result_fifo.sv
// Small synchronous FIFO holding returned lookup results; supports push and pop in the same cycle.
module ht_result_fifo #(
  parameter  int DEPTH = 3,
  parameter  int WIDTH = 20,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // NOTE: storage has no reset; the count and pointers alone decide which words are meaningful.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // NOTE: state is updated with <= so every register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/hashtable_access_ctrl.sv
// Single-port arbiter in front of the hash-table RAM: merges lookups and updates, absorbs the
// one-cycle read latency and returns in-order results through a valid/ready handshake.
module hashtable_access_ctrl
  import hashtable_pkg::*;
#(
  parameter int OBUF_DEPTH   = 3,
  parameter int UP_BURST_MAX = 8,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [ADDR_W-1:0] lk_addr,
  input  logic [TAG_W-1:0]  lk_tag,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [DATA_W-1:0] up_data,
  output logic [ADDR_W-1:0] ht_addr,
  output logic [DATA_W-1:0] ht_din,
  output logic              ht_we,
  input  logic [DATA_W-1:0] ht_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_idx,
  output logic              res_big,
  output logic [TAG_W-1:0]  res_tag,
  output logic [CNT_W-1:0]  cnt_lookup,
  output logic [CNT_W-1:0]  cnt_big,
  output logic [CNT_W-1:0]  cnt_update,
  output logic              busy
);

  localparam int OCNT_W  = $clog2(OBUF_DEPTH + 1);
  localparam int BURST_W = $clog2(UP_BURST_MAX + 1);

  logic               r_inflight;
  logic [TAG_W-1:0]   r_tag;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0]   r_cnt_lookup;
  logic [CNT_W-1:0]   r_cnt_big;
  logic [CNT_W-1:0]   r_cnt_update;

  logic [OCNT_W-1:0]  w_buf_count;
  logic [OCNT_W:0]    w_outstanding;
  logic [RES_W-1:0]   w_fifo_dout;
  ht_result_t         w_head;
  logic               w_credit;
  logic               w_burst_max;
  logic               w_force_lk;
  logic               w_up_grant;
  logic               w_lk_grant;
  logic               w_pop;

  // Credit looks only at registered state, so res_ready never reaches lk_ready combinationally.
  assign w_outstanding = {1'b0, w_buf_count} + {{OCNT_W{1'b0}}, r_inflight};
  assign w_credit      = w_outstanding < (OCNT_W + 1)'(OBUF_DEPTH);
  assign w_burst_max   = r_burst_cnt == BURST_W'(UP_BURST_MAX);
  assign w_force_lk    = w_burst_max && lk_valid && w_credit;

  assign up_ready   = rst_n && !w_force_lk;
  assign lk_ready   = rst_n && (w_force_lk || (!up_valid && w_credit));
  assign w_up_grant = up_valid && up_ready;
  assign w_lk_grant = lk_valid && lk_ready;

  // NOTE: give every combinational output a value before any branch so no latch is inferred.
  always_comb begin
    ht_addr = lk_addr;
    if (w_up_grant) ht_addr = up_addr;
  end

  assign ht_we  = w_up_grant;
  assign ht_din = up_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight  <= 1'b0;
      r_tag       <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_inflight <= w_lk_grant;
      if (w_lk_grant) r_tag <= lk_tag;
      if (!w_up_grant)       r_burst_cnt <= '0;
      else if (!w_burst_max) r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

  // The read issued last cycle returns now and is captured together with its tag.
  ht_result_fifo #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (RES_W)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight),
    .din   (make_result(ht_dout, r_tag)),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .count (w_buf_count)
  );

  assign w_head    = ht_result_t'(w_fifo_dout);
  assign res_valid = w_buf_count != '0;
  assign w_pop     = res_valid && res_ready;
  assign res_idx   = w_head.idx;
  assign res_big   = w_head.big;
  assign res_tag   = w_head.tag;
  assign busy      = r_inflight || res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_lookup <= '0;
      r_cnt_big    <= '0;
      r_cnt_update <= '0;
    end else begin
      if (r_inflight && !(&r_cnt_lookup)) r_cnt_lookup <= r_cnt_lookup + 1'b1;
      if (r_inflight && ht_dout[BIG_BIT] && !(&r_cnt_big)) r_cnt_big <= r_cnt_big + 1'b1;
      if (w_up_grant && !(&r_cnt_update)) r_cnt_update <= r_cnt_update + 1'b1;
    end
  end

  assign cnt_lookup = r_cnt_lookup;
  assign cnt_big    = r_cnt_big;
  assign cnt_update = r_cnt_update;

endmodule
